// File: rtl/sti_pkg.sv
// rtl/sti_pkg.sv - shared STI frame-length encodings, MSB positions and FSM states
package sti_pkg;

  localparam logic [1:0] STI_LEN8  = 2'd0;
  localparam logic [1:0] STI_LEN16 = 2'd1;
  localparam logic [1:0] STI_LEN24 = 2'd2;
  localparam logic [1:0] STI_LEN32 = 2'd3;

  // Index of the frame MSB for each length encoding.
  localparam logic [4:0] STI_MSB_BIT [4] = '{5'd7, 5'd15, 5'd23, 5'd31};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } sti_state_t;

endpackage

// File: rtl/sti_word_extract.sv
// rtl/sti_word_extract.sv - maps a received STI frame buffer to its 16-bit payload
module sti_word_extract
  import sti_pkg::*;
(
  input  logic [31:0] i_fbuf,
  input  logic [1:0]  i_len,
  input  logic        i_fill,
  input  logic        i_low,
  output logic [15:0] o_word
);

  always_comb begin
    o_word = 16'h0000;
    case (i_len)
      STI_LEN8:  o_word = i_low ? {i_fbuf[7:0], 8'h00} : {8'h00, i_fbuf[7:0]};
      STI_LEN16: o_word = i_fbuf[15:0];
      STI_LEN24: o_word = i_fill ? i_fbuf[23:8] : i_fbuf[15:0];
      STI_LEN32: o_word = i_fill ? i_fbuf[31:16] : i_fbuf[15:0];
      default:   o_word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/sti_sipo.sv
// rtl/sti_sipo.sv - STI serial-to-parallel receiver: rebuilds one 16-bit word per frame
module sti_sipo
  import sti_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        si_data,
  input  logic        si_valid,
  input  logic [1:0]  cfg_length,
  input  logic        cfg_fill,
  input  logic        cfg_msb,
  input  logic        cfg_low,
  output logic [15:0] po_data,
  output logic        po_valid,
  output logic        po_err,
  output logic        busy
);

  sti_state_t  r_state;
  sti_state_t  w_state_nxt;
  logic [4:0]  r_cnt;
  logic [31:0] r_fbuf;
  logic [1:0]  r_len;
  logic        r_fill;
  logic        r_msb;
  logic        r_low;
  logic [4:0]  r_msb_bit;
  logic        r_done;
  logic        r_trunc;
  logic [15:0] r_po_data;
  logic        r_po_valid;
  logic        r_po_err;
  logic        r_busy;

  logic        w_start;
  logic        w_last;
  logic        w_trunc;
  logic [4:0]  w_start_msb_bit;
  logic [4:0]  w_idx;
  logic [15:0] w_payload;

  assign w_start         = (r_state == ST_IDLE) && si_valid;
  assign w_last          = (r_state == ST_RECV) && si_valid && (r_cnt == r_msb_bit);
  assign w_trunc         = (r_state == ST_RECV) && !si_valid;
  assign w_start_msb_bit = STI_MSB_BIT[cfg_length];

  // The first bit is placed with the live config; later bits use the shadow copy.
  assign w_idx = w_start ? (cfg_msb ? w_start_msb_bit : 5'd0)
                         : (r_msb ? (r_msb_bit - r_cnt) : r_cnt);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (si_valid) w_state_nxt = ST_RECV;
      ST_RECV: if (!si_valid || (r_cnt == r_msb_bit)) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Completed frames stay in r_fbuf for one more cycle, so the word is
  // extracted from the registered buffer while a back-to-back frame starts.
  sti_word_extract u_extract (
    .i_fbuf (r_fbuf),
    .i_len  (r_len),
    .i_fill (r_fill),
    .i_low  (r_low),
    .o_word (w_payload)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt      <= 5'd0;
      r_fbuf     <= 32'd0;
      r_len      <= STI_LEN8;
      r_fill     <= 1'b0;
      r_msb      <= 1'b0;
      r_low      <= 1'b0;
      r_msb_bit  <= 5'd0;
      r_done     <= 1'b0;
      r_trunc    <= 1'b0;
      r_po_data  <= 16'h0000;
      r_po_valid <= 1'b0;
      r_po_err   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_done     <= w_last;
      r_trunc    <= w_trunc;
      r_po_valid <= r_done;
      r_po_err   <= r_trunc;
      r_busy     <= (w_state_nxt == ST_RECV);
      if (r_done) r_po_data <= w_payload;

      if (w_start) begin
        r_len     <= cfg_length;
        r_fill    <= cfg_fill;
        r_msb     <= cfg_msb;
        r_low     <= cfg_low;
        r_msb_bit <= w_start_msb_bit;
        r_fbuf    <= 32'(si_data) << w_idx;
        r_cnt     <= 5'd1;
      end else if (r_state == ST_RECV) begin
        if (si_valid) begin
          r_fbuf[w_idx] <= si_data;
          r_cnt         <= w_last ? 5'd0 : (r_cnt + 5'd1);
        end else begin
          r_cnt <= 5'd0;
        end
      end
    end
  end

  assign po_data  = r_po_data;
  assign po_valid = r_po_valid;
  assign po_err   = r_po_err;
  assign busy     = r_busy;

endmodule

// File: doc/sti_sipo.md
# sti_sipo

Serial-to-parallel receiver for the STI serial stream (`so_data`/`so_valid`) produced by the STI transmitter. It samples each frame bit by bit and uses the same length, fill, bit-order and byte-select configuration as the transmitter to rebuild the original 16-bit parallel word. It sits on the verification/loopback side of the STI link and feeds a downstream consumer with one word per frame, plus an error pulse for truncated frames.

## Interface
- Parameters: none (frame widths fixed at 8/16/24/32).
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `si_data`  in  1  serial data bit; sampled when `si_valid`=1.
- `si_valid`  in  1  serial bit qualifier.
- `cfg_length`  in  2  frame length: 0=8, 1=16, 2=24, 3=32 bits.
- `cfg_fill`  in  1  24/32-bit frames: 1 = payload in the upper 16 bits, 0 = payload in [15:0].
- `cfg_msb`  in  1  1 = first bit is the frame MSB, 0 = first bit is bit 0.
- `cfg_low`  in  1  8-bit frames: 1 = payload goes to `po_data[15:8]`, 0 = to `po_data[7:0]`.
- `po_data`  out  16  reconstructed word; holds its value between updates.
- `po_valid`  out  1  one-cycle pulse when `po_data` updates.
- `po_err`  out  1  one-cycle pulse when a frame is truncated.
- `busy`  out  1  a frame is partially received.

## Operation
- States:
  - `IDLE`: `busy`=0.
  - `RECV`: `busy`=1, bit counter `cnt`[4:0], 32-bit frame buffer `fbuf`.
- Frame start (`IDLE`, `si_valid`=1):
  - Latch `cfg_*` into shadow registers and derive `msb_bit` ∈ {7,15,23,31}.
  - Clear `fbuf`.
  - Store the first bit and set `cnt`=1.
  - Go to `RECV`.
- Bit index for each bit: `cfg_msb` ? `msb_bit`−`cnt` : `cnt`. The bit is written to `fbuf[index]`. All arithmetic is 5-bit.
- Configuration changes during `RECV` are ignored. The shadow copy governs the whole frame.
- Last bit (`si_valid`=1 and `cnt`==`msb_bit`):
  - Extract the payload:
    - len 0: `fbuf[7:0]` goes to the `cfg_low`-selected byte; the other byte is 0.
    - len 1: `fbuf[15:0]`.
    - len 2: `cfg_fill` ? `fbuf[23:8]` : `fbuf[15:0]`.
    - len 3: `cfg_fill` ? `fbuf[31:16]` : `fbuf[15:0]`.
  - Register the payload into `po_data` and pulse `po_valid`.
  - Return to `IDLE` with `cnt`=0.
- Back-to-back frames: if `si_valid` stays high after the last bit, that next bit starts a new frame. No gap is required.
- Truncation: `si_valid`=0 while in `RECV` → pulse `po_err` next cycle, discard `fbuf`, go to `IDLE`. `po_data` is not changed.
- Reset values: `po_data`=0, `po_valid`=0, `po_err`=0, `busy`=0, state `IDLE`, `cnt`=0.
- A reset asserted mid-frame drops the frame with no `po_err`.

## Timing
- Latency: `po_valid` goes high in the cycle after the edge that samples the last bit. Rising-edge timeline:
  - edge *n* samples the last bit;
  - edge *n*+1 updates `po_data` and sets `po_valid`, which stays high until edge *n*+2.
- `po_err` uses the same timing: it goes high one edge after the edge that sees `si_valid`=0 while in `RECV`.
- Throughput: one bit per clock, so one word every 8/16/24/32 clocks under continuous `si_valid`.
- `po_valid` and `po_err` are never high in the same cycle.
- `busy` is registered. It is 1 from the edge after the first bit through the edge that samples the last bit.

## Structure
- Package `sti_pkg` holds:
  - length encodings `STI_LEN8`/`16`/`24`/`32`;
  - `STI_MSB_BIT[4]` = {7,15,23,31};
  - the state enum.
  The transmitter shares this package.
- Sub-module `sti_word_extract`: purely combinational; maps (`fbuf`, shadow config) to the 16-bit payload. The top level keeps the FSM, counter and buffer.

## Test plan
- Length 0, `cfg_msb`=1, `cfg_low`=0; bits 1,0,1,0,0,1,0,1 → `po_data`=0x00A5, one-cycle `po_valid` on the 9th edge.
- Length 0, `cfg_msb`=0, `cfg_low`=1; 0xA5 sent LSB-first → `po_data`=0xA500.
- Length 3, `cfg_fill`=1, `cfg_msb`=1; a 32-bit frame of 0x1234_0000 → `po_data`=0x1234. Repeat with `cfg_fill`=0 on 0x0000_1234 → `po_data`=0x1234.
- Two 16-bit frames, 0xBEEF then 0x0F0F, with `si_valid` held high for 32 cycles → two `po_valid` pulses exactly 16 cycles apart, with the correct words.
- 24-bit frame with `si_valid` dropped after 10 bits → `po_err` pulse, `po_valid`=0, `po_data` unchanged, `busy`=0. The next full frame decodes correctly.
- `reset`=0 asserted at bit 5 of a frame → all outputs 0 and no `po_err`. After `reset` is released, the next frame decodes correctly.
